uart_receiver: RTL and testbench
================================

Name: uart_receiver

Overview:
- Serial-to-parallel receive path of the UART; the counterpart to the transmitter.
- Takes the line (uart_rxd, or loop_txd in loopback), oversamples it at 16x using sample_edge, and deframes start/data/parity/stop per the line-control fields (wls, pen, eps, sp).
- Delivers one received character plus per-character status (parity, framing, break) to the receive FIFO/status logic as a single-cycle strobe.

Parameters:
- OVERSAMPLE, 16, sample_edge pulses per bit; must be an even number ≥ 4.
- SYNC_STAGES, 2, flops in the rxd synchronizer.

Ports:
- pclk  input  1  system clock
- preset  input  1  reset; one clock domain, synchronous, active-high
- sample_edge  input  1  one-pclk pulse at OVERSAMPLE x baud rate
- uart_rxd  input  1  external serial input (idle high)
- loop  input  1  1 = receive from loop_txd instead of uart_rxd
- loop_txd  input  1  transmitter loopback output
- wls  input  2  data length: 00=5, 01=6, 10=7, 11=8 bits
- pen  input  1  parity enable
- eps  input  1  even parity select
- sp  input  1  stick parity
- rx_data  output  8  received character, LSB-aligned, upper bits zero
- rx_valid  output  1  one-pclk strobe; rx_data/pe/fe/bi valid in that cycle
- pe  output  1  parity error for the strobed character
- fe  output  1  framing error: first stop bit sampled 0
- bi  output  1  break: data, parity and stop bits all 0
- rx_busy  output  1  high from start detect until return to IDLE

Behaviour:
- Reset: all state returns to IDLE. Tick counter, bit counter, shift register and synchronizer are cleared; synchronizer is preset to 1 (mark). All outputs are 0. A reset mid-frame discards the partial character and produces no strobe.
- Line select: rxd_raw = loop ? loop_txd : uart_rxd, followed by the SYNC_STAGES synchronizer giving rxd_s (2-pclk latency). In loop mode, uart_rxd is ignored.
- State and counter updates occur only on cycles with sample_edge=1, except where noted.
- IDLE: if rxd_s=0, go to START with tick=0. wls, pen, eps and sp are latched here and held for the whole frame; mid-frame changes have no effect.
- START: tick++. At tick=OVERSAMPLE/2-1:
  - rxd_s=0: go to DATA with tick=0, bitcnt=0.
  - rxd_s=1: false start; go to IDLE with no strobe.
- DATA: tick++ (wraps at OVERSAMPLE-1). At tick=OVERSAMPLE-1, shift rxd_s into the character register LSB-first and increment bitcnt. After the bit with index 4+wls, go to PARITY if pen, else STOP.
- PARITY: sample at tick=OVERSAMPLE-1 into pbit, then go to STOP. Expected parity by {sp,eps}:
  - 00: ~^data
  - 01: ^data
  - 10: 1
  - 11: 0
  - pe = pen & (pbit != expected).
- STOP: sample at tick=OVERSAMPLE-1.
  - The next pclk (regardless of sample_edge) asserts rx_valid for exactly one pclk with rx_data, pe, fe=~stop, bi=(data==0)&(~pen|pbit==0)&~stop.
  - Then go to IDLE if stop=1, else BRKWAIT.
  - Only the first stop bit is checked; stb is not an input.
- BRKWAIT: stay until rxd_s=1 is seen on a sample_edge, then IDLE. This gives one character per break regardless of break duration.
- pe, fe and bi are 0 whenever rx_valid=0.
- rx_data holds its last value between strobes.
- rx_busy=1 in START, DATA, PARITY, STOP and BRKWAIT.
- Throughput: a new start bit is detectable on the first sample_edge after the STOP sample. Back-to-back frames with one stop bit are received without loss.
- sample_edge held high on consecutive pclks is legal: each cycle counts as one tick.

Test Plan:
- wls=11, pen=0, frame 0xA5 at 16 ticks/bit → one rx_valid, rx_data=0xA5, pe=fe=bi=0, rx_busy drops after the stop sample.
- wls=10, pen=1, eps=1, sp=0, send 0x41 with parity bit 1 → rx_data=0x41, pe=1. Resend with parity 0 → pe=0. Then sp=1, eps=0, parity 1 → pe=0.
- Glitch: rxd low for 5 ticks, then high → no rx_valid, FSM back in IDLE, following valid frame 0x3C received correctly.
- Break: line held low for 3 frame times with wls=11, pen=1 → exactly one rx_valid with rx_data=0x00, fe=1, bi=1. No further strobes until the line goes high, then a frame 0x55 is received normally.
- Loopback: loop=1, uart_rxd=0 constant, loop_txd carries 5-bit frame 0x1F (wls=00) → rx_data=0x1F, no errors. With loop=0 the same stimulus is ignored.
- Reset: assert preset during DATA bit 3 of 0xFF, release, then send 0x81 → no strobe for the aborted frame, one strobe with 0x81, all outputs 0 during reset.

Source files
------------

// File: rtl/uart_receiver_if.sv
// Receive-side bus of the UART receiver: oversample strobe, serial lines,
// line-control fields and the per-character result with its status flags.
interface uart_receiver_if;
    logic       sample_edge;
    logic       uart_rxd;
    logic       loop;
    logic       loop_txd;
    logic [1:0] wls;
    logic       pen;
    logic       eps;
    logic       sp;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       pe;
    logic       fe;
    logic       bi;
    logic       rx_busy;

    // Driving side: supplies the line and line control, consumes characters
    modport master (
        output sample_edge, uart_rxd, loop, loop_txd, wls, pen, eps, sp,
        input  rx_data, rx_valid, pe, fe, bi, rx_busy
    );

    // Receiver side
    modport slave (
        input  sample_edge, uart_rxd, loop, loop_txd, wls, pen, eps, sp,
        output rx_data, rx_valid, pe, fe, bi, rx_busy
    );
endinterface

// File: rtl/uart_receiver.sv
// UART receive path: selects the line, synchronizes it, oversamples each bit
// and deframes start/data/parity/stop into one strobed character plus status.
module uart_receiver #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input logic           pclk,
    input logic           preset,
    uart_receiver_if.slave bus
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRKWAIT
    } state_t;

    state_t           state;
    logic [TW-1:0]    tick;
    logic [2:0]       bitcnt;
    logic [7:0]       shreg;
    logic             pbit;
    logic [1:0]       wls_l;
    logic             pen_l;
    logic             eps_l;
    logic             sp_l;
    logic [SYNC_STAGES-1:0] sync;
    logic             rxd_raw;
    logic             rxd_s;
    logic [7:0]       char_data;
    logic             exp_parity;

    logic [7:0]       rx_data_q;
    logic             rx_valid_q;
    logic             pe_q;
    logic             fe_q;
    logic             bi_q;
    logic             rx_busy_q;

    assign rxd_raw = bus.loop ? bus.loop_txd : bus.uart_rxd;
    assign rxd_s   = sync[SYNC_STAGES-1];

    // Bits enter at the MSB, so a short character ends up left-aligned;
    // shifting right by (3 - wls) brings it down to the LSB and drops stale bits.
    assign char_data = shreg >> (2'd3 - wls_l);

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.pe       = pe_q;
    assign bus.fe       = fe_q;
    assign bus.bi       = bi_q;
    assign bus.rx_busy  = rx_busy_q;

    // Synchronizer for the selected line, preset to mark so reset never looks like a start bit
    always_ff @(posedge pclk) begin
        if (preset) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rxd_raw};
        end
    end

    // Expected parity bit for the frame's latched parity mode
    always_comb begin
        exp_parity = 1'b0;
        case ({sp_l, eps_l})
            2'b00:   exp_parity = ~^char_data;
            2'b01:   exp_parity = ^char_data;
            2'b10:   exp_parity = 1'b1;
            default: exp_parity = 1'b0;
        endcase
    end

    // Framing state machine; the result strobe is registered one pclk after the stop sample
    always_ff @(posedge pclk) begin
        if (preset) begin
            state      <= IDLE;
            tick       <= '0;
            bitcnt     <= '0;
            shreg      <= '0;
            pbit       <= 1'b0;
            wls_l      <= 2'b00;
            pen_l      <= 1'b0;
            eps_l      <= 1'b0;
            sp_l       <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            bi_q       <= 1'b0;
            rx_busy_q  <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            pe_q       <= 1'b0;
            fe_q       <= 1'b0;
            bi_q       <= 1'b0;
            if (bus.sample_edge) begin
                case (state)
                    IDLE: begin
                        if (!rxd_s) begin
                            state     <= START;
                            tick      <= '0;
                            rx_busy_q <= 1'b1;
                            wls_l     <= bus.wls;
                            pen_l     <= bus.pen;
                            eps_l     <= bus.eps;
                            sp_l      <= bus.sp;
                        end
                    end
                    START: begin
                        if (tick == TICK_MID) begin
                            tick <= '0;
                            if (!rxd_s) begin
                                state  <= DATA;
                                bitcnt <= '0;
                            end else begin
                                state     <= IDLE;
                                rx_busy_q <= 1'b0;
                            end
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                    DATA: begin
                        if (tick == TICK_LAST) begin
                            tick   <= '0;
                            shreg  <= {rxd_s, shreg[7:1]};
                            bitcnt <= bitcnt + 3'd1;
                            if (bitcnt == 3'd4 + {1'b0, wls_l}) begin
                                state <= pen_l ? PARITY : STOP;
                            end
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                    PARITY: begin
                        if (tick == TICK_LAST) begin
                            tick  <= '0;
                            pbit  <= rxd_s;
                            state <= STOP;
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                    STOP: begin
                        if (tick == TICK_LAST) begin
                            tick       <= '0;
                            rx_valid_q <= 1'b1;
                            rx_data_q  <= char_data;
                            pe_q       <= pen_l & (pbit != exp_parity);
                            fe_q       <= ~rxd_s;
                            bi_q       <= (char_data == 8'd0) & (~pen_l | ~pbit) & ~rxd_s;
                            state      <= rxd_s ? IDLE : BRKWAIT;
                            rx_busy_q  <= ~rxd_s;
                        end else begin
                            tick <= tick + TW'(1);
                        end
                    end
                    BRKWAIT: begin
                        if (rxd_s) begin
                            state     <= IDLE;
                            rx_busy_q <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        rx_busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: drives serial frames at 16 ticks per bit
// and checks every strobed character and its status against hand-computed values.
module tb_uart_receiver;

    logic pclk;
    logic preset;
    int   checks;
    int   fails;
    int   strobe_cnt;
    int   prev_cnt;
    logic [7:0] cap_data;
    logic cap_pe;
    logic cap_fe;
    logic cap_bi;
    logic drive_loop;

    uart_receiver_if bus ();

    uart_receiver #(
        .OVERSAMPLE (16),
        .SYNC_STAGES(2)
    ) dut (
        .pclk  (pclk),
        .preset(preset),
        .bus   (bus)
    );

    // 10 ns system clock
    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    // Oversample strobe: high on every other rising edge
    initial begin
        bus.sample_edge = 1'b0;
        forever begin
            @(negedge pclk);
            bus.sample_edge = ~bus.sample_edge;
        end
    end

    // Capture every strobed character away from the active edge
    always @(negedge pclk) begin
        if (bus.rx_valid === 1'b1) begin
            strobe_cnt <= strobe_cnt + 1;
            cap_data   <= bus.rx_data;
            cap_pe     <= bus.pe;
            cap_fe     <= bus.fe;
            cap_bi     <= bus.bi;
        end
    end

    // Hang guard
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic waitTicks(input int n);
        int c;
        c = 0;
        while (c < n) begin
            @(posedge pclk);
            if (bus.sample_edge) c++;
        end
    endtask

    task automatic setLine(input logic b);
        if (drive_loop) bus.loop_txd = b;
        else            bus.uart_rxd = b;
    endtask

    task automatic holdBit(input logic b, input int n);
        @(negedge pclk);
        setLine(b);
        waitTicks(n);
    endtask

    // One frame: start, nbits data LSB-first, optional parity, one stop bit, then idle
    task automatic applyStimulus(input logic [7:0] data, input int nbits,
                                 input logic with_par, input logic par_bit,
                                 input logic stop_bit);
        logic [7:0] d;
        d = data;
        holdBit(1'b0, 16);
        for (int i = 0; i < nbits; i++) holdBit(d[i], 16);
        if (with_par) holdBit(par_bit, 16);
        holdBit(stop_bit, 16);
        holdBit(1'b1, 16);
        @(negedge pclk);
    endtask

    initial begin
        checks       = 0;
        fails        = 0;
        strobe_cnt   = 0;
        cap_data     = '0;
        cap_pe       = 1'b0;
        cap_fe       = 1'b0;
        cap_bi       = 1'b0;
        drive_loop   = 1'b0;
        preset       = 1'b1;
        bus.uart_rxd = 1'b1;
        bus.loop     = 1'b0;
        bus.loop_txd = 1'b1;
        bus.wls      = 2'b11;
        bus.pen      = 1'b0;
        bus.eps      = 1'b0;
        bus.sp       = 1'b0;
        repeat (4) @(negedge pclk);

        // Reset state
        checkOutput("rst_valid", {7'd0, bus.rx_valid}, 8'h00);
        checkOutput("rst_busy",  {7'd0, bus.rx_busy},  8'h00);
        checkOutput("rst_data",  bus.rx_data,          8'h00);
        checkOutput("rst_pe",    {7'd0, bus.pe},       8'h00);
        checkOutput("rst_fe",    {7'd0, bus.fe},       8'h00);
        checkOutput("rst_bi",    {7'd0, bus.bi},       8'h00);
        preset = 1'b0;
        waitTicks(20);

        // 8N1 frame 0xA5
        prev_cnt = strobe_cnt;
        applyStimulus(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        checkOutput("a5_count", 8'(strobe_cnt - prev_cnt), 8'd1);
        checkOutput("a5_data",  cap_data,  8'hA5);
        checkOutput("a5_pe",    {7'd0, cap_pe}, 8'h00);
        checkOutput("a5_fe",    {7'd0, cap_fe}, 8'h00);
        checkOutput("a5_bi",    {7'd0, cap_bi}, 8'h00);
        checkOutput("a5_busy",  {7'd0, bus.rx_busy}, 8'h00);
        checkOutput("a5_hold",  bus.rx_data, 8'hA5);
        checkOutput("a5_idle_pe", {7'd0, bus.pe}, 8'h00);

        // 7 bits even parity, 0x41 has two ones: parity 1 is wrong, 0 is right
        bus.wls = 2'b10;
        bus.pen = 1'b1;
        bus.eps = 1'b1;
        bus.sp  = 1'b0;
        applyStimulus(8'h41, 7, 1'b1, 1'b1, 1'b1);
        checkOutput("par_bad_data", cap_data, 8'h41);
        checkOutput("par_bad_pe",   {7'd0, cap_pe}, 8'h01);
        applyStimulus(8'h41, 7, 1'b1, 1'b0, 1'b1);
        checkOutput("par_good_pe",  {7'd0, cap_pe}, 8'h00);
        bus.sp  = 1'b1;
        bus.eps = 1'b0;
        applyStimulus(8'h41, 7, 1'b1, 1'b1, 1'b1);
        checkOutput("stick1_pe",    {7'd0, cap_pe}, 8'h00);
        checkOutput("stick1_count", 8'(strobe_cnt - prev_cnt), 8'd4);

        // Glitch shorter than half a bit
        bus.wls = 2'b11;
        bus.pen = 1'b0;
        bus.sp  = 1'b0;
        prev_cnt = strobe_cnt;
        holdBit(1'b0, 5);
        holdBit(1'b1, 16);
        @(negedge pclk);
        checkOutput("glitch_count", 8'(strobe_cnt - prev_cnt), 8'd0);
        checkOutput("glitch_busy",  {7'd0, bus.rx_busy}, 8'h00);
        applyStimulus(8'h3C, 8, 1'b0, 1'b0, 1'b1);
        checkOutput("3c_count", 8'(strobe_cnt - prev_cnt), 8'd1);
        checkOutput("3c_data",  cap_data, 8'h3C);

        // Break: low for three frame times, even parity so a zero parity bit is correct
        bus.pen = 1'b1;
        bus.eps = 1'b1;
        prev_cnt = strobe_cnt;
        holdBit(1'b0, 3 * 12 * 16);
        @(negedge pclk);
        checkOutput("brk_count", 8'(strobe_cnt - prev_cnt), 8'd1);
        checkOutput("brk_data",  cap_data, 8'h00);
        checkOutput("brk_fe",    {7'd0, cap_fe}, 8'h01);
        checkOutput("brk_bi",    {7'd0, cap_bi}, 8'h01);
        checkOutput("brk_pe",    {7'd0, cap_pe}, 8'h00);
        checkOutput("brk_busy",  {7'd0, bus.rx_busy}, 8'h01);
        holdBit(1'b1, 16);
        @(negedge pclk);
        checkOutput("brk_release_busy", {7'd0, bus.rx_busy}, 8'h00);
        applyStimulus(8'h55, 8, 1'b1, 1'b0, 1'b1);
        checkOutput("55_count", 8'(strobe_cnt - prev_cnt), 8'd2);
        checkOutput("55_data",  cap_data, 8'h55);
        checkOutput("55_pe",    {7'd0, cap_pe}, 8'h00);
        checkOutput("55_fe",    {7'd0, cap_fe}, 8'h00);
        checkOutput("55_bi",    {7'd0, cap_bi}, 8'h00);

        // Loopback: 5-bit frame on loop_txd while uart_rxd sits low
        bus.wls      = 2'b00;
        bus.pen      = 1'b0;
        bus.eps      = 1'b0;
        bus.loop_txd = 1'b1;
        bus.loop     = 1'b1;
        waitTicks(4);
        bus.uart_rxd = 1'b0;
        drive_loop   = 1'b1;
        waitTicks(16);
        prev_cnt = strobe_cnt;
        applyStimulus(8'h1F, 5, 1'b0, 1'b0, 1'b1);
        checkOutput("loop_count", 8'(strobe_cnt - prev_cnt), 8'd1);
        checkOutput("loop_data",  cap_data, 8'h1F);
        checkOutput("loop_fe",    {7'd0, cap_fe}, 8'h00);
        checkOutput("loop_pe",    {7'd0, cap_pe}, 8'h00);

        // Same stimulus with loopback off must be ignored
        bus.uart_rxd = 1'b1;
        waitTicks(4);
        bus.loop = 1'b0;
        waitTicks(16);
        prev_cnt = strobe_cnt;
        applyStimulus(8'h1F, 5, 1'b0, 1'b0, 1'b1);
        checkOutput("noloop_count", 8'(strobe_cnt - prev_cnt), 8'd0);
        checkOutput("noloop_busy",  {7'd0, bus.rx_busy}, 8'h00);
        checkOutput("noloop_hold",  bus.rx_data, 8'h1F);
        drive_loop = 1'b0;

        // Reset in the middle of data bit 3 of 0xFF
        bus.wls  = 2'b11;
        prev_cnt = strobe_cnt;
        holdBit(1'b0, 16);
        holdBit(1'b1, 3 * 16);
        holdBit(1'b1, 10);
        checkOutput("pre_rst_busy", {7'd0, bus.rx_busy}, 8'h01);
        @(negedge pclk);
        preset = 1'b1;
        repeat (2) @(negedge pclk);
        checkOutput("mid_rst_valid", {7'd0, bus.rx_valid}, 8'h00);
        checkOutput("mid_rst_busy",  {7'd0, bus.rx_busy},  8'h00);
        checkOutput("mid_rst_data",  bus.rx_data,          8'h00);
        checkOutput("mid_rst_flags", {5'd0, bus.pe, bus.fe, bus.bi}, 8'h00);
        preset = 1'b0;
        waitTicks(16 * 8);
        @(negedge pclk);
        checkOutput("abort_count", 8'(strobe_cnt - prev_cnt), 8'd0);
        applyStimulus(8'h81, 8, 1'b0, 1'b0, 1'b1);
        checkOutput("81_count", 8'(strobe_cnt - prev_cnt), 8'd1);
        checkOutput("81_data",  cap_data, 8'h81);
        checkOutput("81_flags", {5'd0, cap_pe, cap_fe, cap_bi}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
